// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_types_pkg
//  Description : Shared CPU datapath types: machine word, RAM status codes,
//                memory-arbiter FSM state and the arbiter timeout default.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

    // 32-bit machine word used for addresses and data.
    typedef logic [31:0] word_t;

    // Status reported by the RAM model/controller each cycle.
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Memory arbiter grant state.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DSERVE = 2'd1,
        ISERVE = 2'd2
    } arb_state_t;

    // Default number of BUSY cycles tolerated before a RAM access is aborted.
    localparam int ARB_TIMEOUT_DEFAULT = 255;

endpackage : cpu_types_pkg
`default_nettype wire

// File: rtl/memory_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : memory_arbiter_if
//  Description : Bundle of request-unit and RAM signals around the memory
//                arbiter.
//                Requester side : iREN, iaddr, dREN, dWEN, daddr, dstore
//                                 -> iwait, dwait, iload, dload
//                RAM side       : ramstate, ramload
//                                 -> ramREN, ramWEN, ramaddr, ramstore
//                Status         : memerr (sticky error / timeout flag)
//                Modport slave  : the arbiter. Modport master : its environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface memory_arbiter_if;
    import cpu_types_pkg::*;

    // Requests from the request unit
    logic      iREN;
    word_t     iaddr;
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;

    // RAM responses
    ramstate_t ramstate;
    word_t     ramload;

    // RAM commands
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;

    // Replies to the request unit
    logic      iwait;
    logic      dwait;
    word_t     iload;
    word_t     dload;
    logic      memerr;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
        output ramREN, ramWEN, ramaddr, ramstore, iwait, dwait, iload, dload,
               memerr
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
        input  ramREN, ramWEN, ramaddr, ramstore, iwait, dwait, iload, dload,
               memerr
    );

endinterface : memory_arbiter_if
`default_nettype wire

// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : memory_arbiter
//  Description : Arbitrates one shared RAM port between an instruction fetch
//                requester and a data requester. Data requests win when both
//                arrive together; a grant is held until the RAM reports
//                ACCESS, ERROR, a timeout, or the request is withdrawn.
//  Ports       : CLK  - system clock (rising edge)
//                RST  - synchronous active-high reset
//                bus  - memory_arbiter_if.slave (requests, RAM, status)
//  Parameters  : TIMEOUT - max BUSY cycles per RAM transaction
//  Revision    : 1.0 - initial release
// ============================================================================
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
    input  wire logic             CLK,
    input  wire logic             RST,
    memory_arbiter_if.slave       bus
);

    // Timer is wide enough to hold TIMEOUT itself, where it saturates.
    localparam int TIMER_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TIMER_W-1:0] c_TIMER_MAX = TIMER_W'(TIMEOUT);

    arb_state_t         state_q,  state_d;
    logic [TIMER_W-1:0] timer_q,  timer_d;
    logic               memerr_q, memerr_d;

    logic               w_dreq;      // any data request (read or write)
    logic               w_live_req;  // request belonging to the current grant
    logic               w_access;    // RAM completes this cycle (not in reset)
    logic [TIMER_W-1:0] w_timer_inc; // saturating timer increment

    assign w_dreq   = bus.dREN | bus.dWEN;
    assign w_access = (bus.ramstate == ACCESS) && !RST;

    assign w_timer_inc = (timer_q == c_TIMER_MAX) ? timer_q
                                                  : timer_q + TIMER_W'(1);

    always_comb begin
        w_live_req = 1'b0;
        unique case (state_q)
            DSERVE:  w_live_req = w_dreq;
            ISERVE:  w_live_req = bus.iREN;
            default: w_live_req = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state, timer and error flag
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        memerr_d = memerr_q;

        unique case (state_q)
            IDLE: begin
                if (w_dreq) begin
                    state_d = DSERVE;
                    timer_d = '0;
                end else if (bus.iREN) begin
                    state_d = ISERVE;
                    timer_d = '0;
                end
            end

            DSERVE, ISERVE: begin
                if (!w_live_req) begin
                    // Requester withdrew: abandon the transaction.
                    state_d = IDLE;
                end else begin
                    unique case (bus.ramstate)
                        ACCESS: state_d = IDLE;
                        ERROR: begin
                            memerr_d = 1'b1;
                            state_d  = IDLE;
                        end
                        BUSY: begin
                            timer_d = w_timer_inc;
                            // Abort at the edge ending the TIMEOUT-th BUSY cycle.
                            if (w_timer_inc == c_TIMER_MAX) begin
                                memerr_d = 1'b1;
                                state_d  = IDLE;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // RAM command and requester reply outputs
    // ------------------------------------------------------------------
    always_comb begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;

        unique case (state_q)
            DSERVE: begin
                // Read+write together is treated as a write.
                bus.ramREN   = bus.dREN & ~bus.dWEN;
                bus.ramWEN   = bus.dWEN;
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
            end
            ISERVE: begin
                // Strobe follows the live request so an abort drops it at once.
                bus.ramREN  = bus.iREN;
                bus.ramaddr = bus.iaddr;
            end
            default: ;
        endcase

        // A completion is never signalled while reset is applied.
        bus.dwait = w_dreq    & ~((state_q == DSERVE) && w_access);
        bus.iwait = bus.iREN  & ~((state_q == ISERVE) && w_access);
    end

    assign bus.iload  = bus.ramload;
    assign bus.dload  = bus.ramload;
    assign bus.memerr = memerr_q;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            memerr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            memerr_q <= memerr_d;
        end
    end

endmodule : memory_arbiter
`default_nettype wire

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 The block SHALL have this parameter: TIMEOUT, default 255, maximum cycles one RAM transaction may remain BUSY before abort.
REQ-002 The block SHALL have port CLK, input, 1 bit: the system clock; one clock domain, all state changes on its rising edge.
REQ-003 The block SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port iREN, input, 1 bit: instruction read request from the request unit.
REQ-005 The block SHALL have port iaddr, input, word_t: instruction address.
REQ-006 The block SHALL have port dREN / dWEN, input, 1 bit each: data read and data write requests; both high is illegal.
REQ-007 The block SHALL have port daddr / dstore, input, word_t each: data address and write data.
REQ-008 The block SHALL have port ramstate, input, ramstate_t: RAM status, one of FREE, BUSY, ACCESS or ERROR.
REQ-009 The block SHALL have port ramload, input, word_t: RAM read data.
REQ-010 The block SHALL have port ramREN / ramWEN, output, 1 bit each: RAM read and write strobes.
REQ-011 The block SHALL have port ramaddr / ramstore, output, word_t each: RAM address and write data.
REQ-012 The block SHALL have port iwait / dwait, output, 1 bit each: requester stall; low means the access completed this cycle.
REQ-013 The block SHALL have port iload / dload, output, word_t each: read data returned to the requesters.
REQ-014 The block SHALL have port memerr, output, 1 bit: sticky flag for an ERROR status or a timeout.

Function
REQ-015 The FSM SHALL have three states: IDLE, DSERVE, ISERVE.
REQ-016 In IDLE with (dREN|dWEN) high, the FSM SHALL go to DSERVE; otherwise with iREN high it SHALL go to ISERVE; otherwise it SHALL stay in IDLE.
REQ-017 Arbitration SHALL have one cycle of latency: a request sampled in IDLE at edge t drives RAM strobes from cycle t+1.
REQ-018 A grant SHALL hold until its transaction ends; a data request arriving during ISERVE SHALL NOT preempt it.
REQ-019 In DSERVE, the block SHALL drive ramREN=dREN, ramWEN=dWEN, ramaddr=daddr and ramstore=dstore.
REQ-020 In ISERVE, the block SHALL drive ramREN=1, ramWEN=0, ramaddr=iaddr and ramstore=0.
REQ-021 In IDLE, ramREN, ramWEN, ramaddr and ramstore SHALL all be 0.
REQ-022 dwait SHALL be 0 only in DSERVE with ramstate==ACCESS; iwait SHALL be 0 only in ISERVE with ramstate==ACCESS; otherwise each SHALL equal its request (dREN|dWEN, or iREN).
REQ-023 iload and dload SHALL both equal ramload, combinationally.
REQ-024 The transaction SHALL end and the FSM SHALL return to IDLE on ramstate==ACCESS; a request still pending is re-arbitrated from IDLE on the next cycle.
REQ-025 On ramstate==ERROR, the block SHALL set memerr, hold the requester's wait high and return to IDLE.
REQ-026 A timer SHALL clear on entry to DSERVE/ISERVE and increment each cycle ramstate is BUSY.
REQ-027 When the timer reaches TIMEOUT, the block SHALL set memerr and return to IDLE.
REQ-028 The timer SHALL saturate and never wrap.
REQ-029 If the served request drops mid-transaction (abort), the FSM SHALL return to IDLE next edge, and strobes SHALL follow the live request, reaching 0 in the abort cycle.
REQ-030 memerr SHALL be cleared only by RST.
REQ-031 dREN and dWEN both high SHALL be treated as a write (ramREN forced to 0).

Reset
REQ-032 While RST is high at a rising edge, the block SHALL reset the state to IDLE, the timer to 0 and memerr to 0.
REQ-033 As a consequence of reset, ram strobes SHALL be 0 the following cycle; reset mid-transaction SHALL abandon the transaction with no completion indicated.

Structure
REQ-034 word_t and ramstate_t SHALL come from cpu_types_pkg.
REQ-035 The arbiter state enum and the TIMEOUT default SHALL be added to cpu_types_pkg.
REQ-036 The block SHALL be a single module with no sub-module; the timer is inline.

Verification
REQ-037 Reset then idle: RST=1 for 2 cycles -> ramREN=ramWEN=0, iwait=dwait=0, memerr=0.
REQ-038 Instruction read: iREN=1, iaddr=0x40; RAM BUSY 2 cycles then ACCESS with ramload=0x8C220004 -> ramREN=1 and ramaddr=0x40 from cycle 1; iwait=0 and iload=0x8C220004 exactly in the ACCESS cycle.
REQ-039 Simultaneous requests: iREN=1 and dWEN=1 (daddr=0x100, dstore=0xDEADBEEF) in the same cycle -> data served first (ramWEN=1, ramaddr=0x100); ISERVE starts 1 cycle after the data ACCESS.
REQ-040 No preemption: dREN rises 1 cycle into ISERVE -> ramaddr stays iaddr until ACCESS; dwait=1 throughout.
REQ-041 Timeout: ramstate held BUSY with TIMEOUT=4 -> return to IDLE after 4 BUSY cycles, memerr=1 and held until RST.
REQ-042 Abort and ERROR: dREN drops mid-DSERVE -> IDLE next edge with strobes 0; a separate ERROR response -> memerr=1 and dwait stays 1.
